multicycle_ctl: RTL and testbench

//  Main control FSM of the multicycle RV32 datapath; the producer side of the ALUOp/Funct interface.

---
 rtl/mc_defs_pkg.sv | 35 +++
 rtl/mc_mem_wait.sv | 33 +++
 rtl/multicycle_ctl.sv | 174 +++++++++++++++++
 tb/tb_multicycle_ctl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_defs_pkg.sv
// Shared definitions for the multicycle RV32 control path: opcodes, FSM states,
// ALUOp contract (shared with the ALU control decoder) and datapath mux encodings.
package mc_defs;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JAL
  } state_t;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait watchdog: counts consecutive cycles a memory state waits with
// mem_ready low and raises abort when the count reaches MEM_TIMEOUT (0 disables).
module mc_mem_wait #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic abort
);

  logic [TMO_W-1:0] count;

  always_comb begin
    abort = waiting && !mem_ready && (MEM_TIMEOUT != 0) &&
            (count == TMO_W'(MEM_TIMEOUT));
  end

  // Any completion, abort or non-waiting cycle leaves the count at zero, so
  // every entry into a waiting state (including FETCH after an abort) starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (waiting && !mem_ready && !abort) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/multicycle_ctl.sv
// Main control FSM of the multicycle RV32 datapath (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature: define MC_JAL_EN to decode JAL (opcode 1101111) into the JAL state.
module multicycle_ctl
  import mc_defs::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] dbg_state
);

  // Memory handshake: a request (MemRead/MemWrite) is held every cycle until the
  // cycle mem_ready is 1, which completes the access; otherwise the watchdog aborts it.
  state_t state, next;
  logic   is_store;
  logic   waiting;
  logic   abort;

  assign waiting   = is_mem_wait(state);
  assign dbg_state = state;

  mc_mem_wait #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_mem_wait (
    .clk       (clk),
    .reset     (reset),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .abort     (abort)
  );

  // The load/store choice is captured in DECODE so later opcode changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= next;
      if (state == S_DECODE) is_store <= (opcode == OP_STORE);
    end
  end

  always_comb begin
    next        = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            next    = S_DECODE;
          end else if (abort) begin
            mem_timeout = 1'b1;
            next        = S_FETCH;
          end
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM;
          case (opcode)
            OP_RTYPE:           next = S_EXEC_R;
            OP_ITYPE:           next = S_EXEC_I;
            OP_LOAD, OP_STORE:  next = S_MEMADR;
            OP_BRANCH:          next = S_BRANCH;
`ifdef MC_JAL_EN
            OP_JAL:             next = S_JAL;
`endif
            default: begin
              illegal_op = 1'b1;
              next       = S_FETCH;
            end
          endcase
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_RTYPE;
          next    = S_ALUWB;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ITYPE;
          next    = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          next     = S_FETCH;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          next    = is_store ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) begin
            next = S_MEMWB;
          end else if (abort) begin
            mem_timeout = 1'b1;
            next        = S_FETCH;
          end
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          next     = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) begin
            next = S_FETCH;
          end else if (abort) begin
            mem_timeout = 1'b1;
            next        = S_FETCH;
          end
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          next        = S_FETCH;
        end
`ifdef MC_JAL_EN
        S_JAL: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          next     = S_FETCH;
        end
`endif
        default: next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctl.sv
// Bench for multicycle_ctl: instruction-level reference model expands each
// instruction into per-cycle expected control words checked under a field mask.
module tb_multicycle_ctl;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  // Control word layout, bit 16 down to 0.
  localparam int B_PCW = 16, B_PCWC = 15, B_IORD = 14, B_MRD = 13, B_MWR = 12;
  localparam int B_IRW = 11, B_M2R = 10, B_RW = 9, B_SRCA = 8, B_ILL = 1, B_TMO = 0;

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC_R = 2, PH_EXEC_I = 3, PH_ALUWB = 4;
  localparam int PH_MEMADR = 5, PH_MEMRD = 6, PH_MEMWB = 7, PH_MEMWR = 8, PH_BRANCH = 9;
  localparam int PH_JAL = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
  logic       ALUSrcA, illegal_op, mem_timeout;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] dbg_state;

  logic [9:0]  in_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] msk_q[$];
  int compared = 0;
  int mismatched = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multicycle_ctl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [6:0] op);
    bit ok;
    ok = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
`ifdef MC_JAL_EN
    if (op == OP_J) ok = 1'b1;
`endif
    return ok;
  endfunction

  // Expected control word for one cycle of a phase; mask marks fields the phase defines.
  function automatic void exp_for(input int ph, input bit rdy, input bit tmo, input bit ill,
                                  output logic [16:0] v, output logic [16:0] m);
    v = '0;
    m = '0;
    m[B_PCW] = 1'b1; m[B_PCWC] = 1'b1; m[B_MRD] = 1'b1; m[B_MWR] = 1'b1;
    m[B_IRW] = 1'b1; m[B_RW] = 1'b1; m[B_ILL] = 1'b1; m[B_TMO] = 1'b1;
    case (ph)
      PH_FETCH: begin
        v[B_MRD] = 1'b1; v[B_PCW] = rdy; v[B_IRW] = rdy; v[B_TMO] = tmo;
        v[7:6] = 2'b01;
        m[B_IORD] = 1'b1; m[B_SRCA] = 1'b1; m[7:6] = 2'b11; m[5:4] = 2'b11; m[3:2] = 2'b11;
      end
      PH_DECODE: begin
        v[B_ILL] = ill; v[7:6] = 2'b10;
        m[B_SRCA] = 1'b1; m[7:6] = 2'b11; m[5:4] = 2'b11;
      end
      PH_EXEC_R: begin
        v[B_SRCA] = 1'b1; v[7:6] = 2'b00; v[5:4] = 2'b10;
        m[B_SRCA] = 1'b1; m[7:6] = 2'b11; m[5:4] = 2'b11;
      end
      PH_EXEC_I: begin
        v[B_SRCA] = 1'b1; v[7:6] = 2'b10; v[5:4] = 2'b11;
        m[B_SRCA] = 1'b1; m[7:6] = 2'b11; m[5:4] = 2'b11;
      end
      PH_ALUWB: begin
        v[B_RW] = 1'b1; m[B_M2R] = 1'b1;
      end
      PH_MEMADR: begin
        v[B_SRCA] = 1'b1; v[7:6] = 2'b10; v[5:4] = 2'b00;
        m[B_SRCA] = 1'b1; m[7:6] = 2'b11; m[5:4] = 2'b11;
      end
      PH_MEMRD: begin
        v[B_MRD] = 1'b1; v[B_IORD] = 1'b1; v[B_TMO] = tmo; m[B_IORD] = 1'b1;
      end
      PH_MEMWB: begin
        v[B_RW] = 1'b1; v[B_M2R] = 1'b1; m[B_M2R] = 1'b1;
      end
      PH_MEMWR: begin
        v[B_MWR] = 1'b1; v[B_IORD] = 1'b1; v[B_TMO] = tmo; m[B_IORD] = 1'b1;
      end
      PH_BRANCH: begin
        v[B_SRCA] = 1'b1; v[7:6] = 2'b00; v[5:4] = 2'b01; v[B_PCWC] = 1'b1; v[3:2] = 2'b01;
        m[B_SRCA] = 1'b1; m[7:6] = 2'b11; m[5:4] = 2'b11; m[3:2] = 2'b11;
      end
      PH_JAL: begin
        v[B_RW] = 1'b1; v[B_PCW] = 1'b1; v[3:2] = 2'b10;
        m[B_M2R] = 1'b1; m[3:2] = 2'b11;
      end
      default: ;
    endcase
  endfunction

  task automatic push(input int ph, input bit rdy, input bit tmo, input bit ill, input logic [6:0] op);
    logic [16:0] v, m;
    exp_for(ph, rdy, tmo, ill, v, m);
    in_q.push_back({1'b0, rdy, 1'($urandom), op});
    exp_q.push_back(v);
    msk_q.push_back(m);
  endtask

  task automatic push_reset();
    in_q.push_back({1'b1, 1'b1, 1'($urandom), 7'($urandom)});
    exp_q.push_back('0);
    msk_q.push_back('1);
  endtask

  // A memory phase waits w cycles with mem_ready low; the 16th low cycle aborts.
  task automatic model_wait(input int ph, input int w, output bit aborted);
    aborted = 1'b0;
    for (int c = 0; c <= w; c++) begin
      if (c < w && c == MEM_TIMEOUT) begin
        push(ph, 1'b0, 1'b1, 1'b0, 7'($urandom));
        aborted = 1'b1;
        return;
      end
      push(ph, (c >= w), 1'b0, 1'b0, 7'($urandom));
    end
  endtask

  task automatic model_instr(input logic [6:0] op, input int fw, input int mw);
    bit ab;
    model_wait(PH_FETCH, fw, ab);
    if (ab) return;
    push(PH_DECODE, 1'($urandom), 1'b0, !is_legal(op), op);
    if (!is_legal(op)) return;
    case (op)
      OP_R: begin
        push(PH_EXEC_R, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
        push(PH_ALUWB, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
      end
      OP_I: begin
        push(PH_EXEC_I, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
        push(PH_ALUWB, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
      end
      OP_LD: begin
        push(PH_MEMADR, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
        model_wait(PH_MEMRD, mw, ab);
        if (!ab) push(PH_MEMWB, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
      end
      OP_ST: begin
        push(PH_MEMADR, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
        model_wait(PH_MEMWR, mw, ab);
      end
      OP_BR: push(PH_BRANCH, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
      default: push(PH_JAL, 1'($urandom), 1'b0, 1'b0, 7'($urandom));
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic [9:0] in, output logic [16:0] o);
    @(negedge clk);
    reset     = in[9];
    mem_ready = in[8];
    zero      = in[7];
    opcode    = in[6:0];
    #1;
    o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
         ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_timeout};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [16:0] o, e, m;
    push_reset();
    push_reset();
    model_instr(OP_I, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL reset: got %h want %h (mask %h, state %0d)", o & m, e & m, m, dbg_state);
      end
    end
  endtask

  task automatic test_rtype();
    logic [16:0] o, e, m;
    int n, writes;
    n = 0;
    writes = 0;
    model_instr(OP_R, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n++;
      writes += int'(o[B_RW]);
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL rtype cycle %0d: got %h want %h (mask %h)", n, o & m, e & m, m);
      end
    end
    compared++;
    if (writes !== 1) begin
      mismatched++;
      $display("FAIL rtype_regwrite_count: got %0d want 1", writes);
    end
  endtask

  task automatic test_itype_load_wait();
    logic [16:0] o, e, m;
    int held;
    held = 0;
    model_instr(OP_I, 1, 0);
    model_instr(OP_LD, 0, 3);
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      if (o[B_MRD] && o[B_IORD]) held++;
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL itype_load: got %h want %h (mask %h, state %0d)", o & m, e & m, m, dbg_state);
      end
    end
    compared++;
    if (held !== 4) begin
      mismatched++;
      $display("FAIL load_memrd_hold: got %0d cycles want 4", held);
    end
  endtask

  task automatic test_branch();
    logic [16:0] o, e, m;
    int n;
    n = 0;
    model_instr(OP_BR, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      n++;
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL branch cycle %0d: got %h want %h (mask %h)", n, o & m, e & m, m);
      end
    end
  endtask

  task automatic test_timeout();
    logic [16:0] o, e, m;
    int pulses;
    pulses = 0;
    model_instr(OP_ST, 0, 16);
    model_instr(OP_ST, 0, 15);
    model_instr(OP_LD, 0, 16);
    model_instr(OP_R, 16, 0);
    model_instr(OP_R, 15, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      pulses += int'(o[B_TMO]);
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL timeout: got %h want %h (mask %h, state %0d)", o & m, e & m, m, dbg_state);
      end
    end
    compared++;
    if (pulses !== 3) begin
      mismatched++;
      $display("FAIL timeout_pulse_count: got %0d want 3", pulses);
    end
  endtask

  task automatic test_jal();
    logic [16:0] o, e, m;
    int jumps, ills;
    jumps = 0;
    ills = 0;
    model_instr(OP_J, 0, 0);
    model_instr(OP_R, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      if (o[3:2] == 2'b10) jumps++;
      ills += int'(o[B_ILL]);
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL jal: got %h want %h (mask %h, state %0d)", o & m, e & m, m, dbg_state);
      end
    end
    compared++;
`ifdef MC_JAL_EN
    if (jumps !== 1 || ills !== 0) begin
`else
    if (jumps !== 0 || ills !== 1) begin
`endif
      mismatched++;
      $display("FAIL jal_decode: got jumps=%0d illegal=%0d", jumps, ills);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] o, e, m;
    push(PH_FETCH, 1'b1, 1'b0, 1'b0, 7'($urandom));
    push(PH_DECODE, 1'b1, 1'b0, 1'b0, OP_LD);
    push(PH_MEMADR, 1'b1, 1'b0, 1'b0, 7'($urandom));
    push(PH_MEMRD, 1'b0, 1'b0, 1'b0, 7'($urandom));
    push_reset();
    model_instr(OP_ST, 0, 0);
    push(PH_FETCH, 1'b1, 1'b0, 1'b0, 7'($urandom));
    push(PH_DECODE, 1'b1, 1'b0, 1'b0, OP_R);
    push(PH_EXEC_R, 1'b1, 1'b0, 1'b0, 7'($urandom));
    push_reset();
    model_instr(OP_BR, 0, 0);
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL reset_mid: got %h want %h (mask %h, state %0d)", o & m, e & m, m, dbg_state);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] o, e, m;
    logic [6:0] op;
    int fw, mw;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 6))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LD;
        3: op = OP_ST;
        4: op = OP_BR;
        5: op = OP_J;
        default: begin
          op = 7'($urandom);
          if (is_legal(op) || op == OP_J) op = 7'b1111111;
        end
      endcase
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
      model_instr(op, fw, mw);
    end
    while (exp_q.size() > 0) begin
      drive_cycle(in_q.pop_front(), o);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      compared++;
      if ((o & m) !== (e & m)) begin
        mismatched++;
        $display("FAIL random: got %h want %h (mask %h, state %0d)", o & m, e & m, m, dbg_state);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rtype();
    test_itype_load_wait();
    test_branch();
    test_timeout();
    test_jal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
